key_tone_scheduler: RTL and testbench
=====================================

# key_tone_scheduler

Front-end controller for the Lab2 keyboard tone path. Debounces the 9-bit `key_input`, which carries a 2-bit octave and 7 one-hot note keys. Arbitrates simultaneous presses down to one note and sequences it into a square-wave tone with play/gap phases. Drives the tone enable into the PWM stage, plus the 5-bit LED note display.

## Interface
- `CLK_DIV`, 100: system clocks per 1 MHz tick (100 MHz → 1 MHz).
- `DEBOUNCE_TICKS`, 1000: ticks a sampled key vector must stay stable before acceptance.
- `GAP_TICKS`, 2000: silent ticks enforced after a note release.
- `clk`  in  1  system clock, 100 MHz; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_input`  in  9  `[8:7]` octave (0–3), `[6:0]` note keys C..B; bit 0 = C.
- `tick`  out  1  one-cycle 1 MHz strobe, exported for the PWM stage.
- `tone_en`  out  1  high while a note sounds (PLAY state).
- `tone_out`  out  1  square wave at the selected note frequency; 0 when not playing.
- `led`  out  5  `{octave, note_code}`; `note_code` is 1..7 for C..B, 0 = none.

## Operation
- **Prescaler.**
  - Counts 0..CLK_DIV-1.
  - `tick` = 1 in the cycle the count equals CLK_DIV-1, then the count wraps to 0.
- **Sampling.** `key_input` passes through a 2-flop synchronizer and is sampled only on `tick`.
- **Debounce.**
  - If the sample differs from `cand`: `cand` <= sample and `stab_cnt` <= 0.
  - Otherwise `stab_cnt` increments, saturating.
  - When `stab_cnt` reaches DEBOUNCE_TICKS-1, `stable_keys` <= `cand`.
  - Any glitch shorter than DEBOUNCE_TICKS ticks never reaches `stable_keys`.
- **Arbitration.** Fixed priority, lowest set bit of `stable_keys[6:0]` wins.
  - Evaluated only in IDLE.
  - Once a note is latched it is held until its own key releases, even if a lower-index key is pressed.
- **FSM states.**
  - IDLE: `tone_en` = 0. Any `stable_keys[6:0]` ≠ 0 → latch `note_code` and octave → PLAY.
  - PLAY: `tone_en` = 1; tone generator runs. Latched key bit clears in `stable_keys` → GAP, with `gap_cnt` <= 0.
  - GAP: `tone_en` = 0 and `tone_out` = 0. `gap_cnt` counts ticks; at GAP_TICKS-1 → IDLE.
- **Tone generator.**
  - Base half-periods in ticks, octave 0: C 1911, D 1703, E 1517, F 1432, G 1276, A 1136, B 1012.
  - Effective half-period = base >> octave; width 11 bits, never 0.
  - `hp_cnt` increments on tick. At half-period-1, `tone_out` toggles and `hp_cnt` <= 0.
  - Entering PLAY clears `hp_cnt` and sets `tone_out` = 0.
- **Octave changes during PLAY.**
  - The new octave is latched into a pending register.
  - It is applied only at the next toggle boundary, so no runt half-cycle is produced.
  - `led` octave updates at that same boundary.
- **`led`.** Holds the last played `{octave, note_code}` through GAP and IDLE. It is 0 after reset.

## Timing
- **Reset values.**
  - `tick`=0, `tone_en`=0, `tone_out`=0, `led`=5'b00000.
  - All counters 0, `stable_keys`=0, FSM=IDLE.
- **Reset mid-operation.** Asserting `rst` in any state immediately forces all reset values (asynchronous). Counting resumes on the first edge after deassertion.
- **Press latency** (clean press at tick k to `tone_en`=1): 2 sync cycles, plus up to 1 tick for sampling, plus DEBOUNCE_TICKS ticks, plus 1 clk for arbitration.
- **First toggle** of `tone_out` occurs half-period ticks after PLAY entry.
- **Release latency** mirrors press latency. `tone_en` falls 1 clk after `stable_keys` drops the latched bit.
- **Simultaneous events.**
  - Release and new press in the same tick: release wins → GAP. The new key is arbitrated only after the gap.
  - Key still held at GAP exit: it is re-arbitrated and replayed.
- **Boundary conditions.**
  - All keys pressed: C wins.
  - `key_input[6:0]`=0 with a nonzero octave: FSM stays IDLE.
  - Prescaler wrap is exact, with no dropped or doubled ticks.

## Structure
- **Shared package `tone_pkg`:**
  - FSM state enum (IDLE, PLAY, GAP).
  - 7-entry base half-period table.
  - Widths: NOTE_W=3, OCT_W=2, HP_W=11.
  - The `note_code` encoding.
- **Sub-module `tick_prescaler`:** parameter CLK_DIV; outputs `tick`. It is reused by the PWM stage.

## Test plan
Run with CLK_DIV=4, DEBOUNCE_TICKS=4, GAP_TICKS=8 for speed.
- **Reset.** Assert `rst` mid-PLAY → all outputs 0 within the same cycle. After release, `tick` period = 4 clk.
- **Basic note.** `key_input`=9'b00_0000001 held → `tone_en`=1 after about 5 ticks; `led`=5'b00001; `tone_out` toggles every 1911 ticks.
- **Octave shift.** `key_input`=9'b11_1000000 → `led`=5'b11111; half-period 1012>>3 = 126 ticks.
- **Bounce.** 2-tick pulse on bit 2, 3-tick low, repeated → `tone_en` never rises. Then hold for 10 ticks → note E plays, `led`=5'b00011.
- **Arbitration/hold.**
  - Press bit 4 (G), then add bit 0 → G keeps playing.
  - Release G → GAP for 8 ticks → C plays, `led`=5'b00001.
- **Octave change mid-note.** Change `[8:7]` from 01 to 10 during A → the current half-period completes at 568 ticks, then 284-tick half-periods follow; no half-cycle is shorter.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types, widths and tone tables for the keyboard tone path.
// Holds the FSM state enum, the key/LED payload structs, the octave-0
// half-period table (in 1 MHz ticks) and small note helpers.
package tone_pkg;

    localparam int unsigned NOTE_W   = 3;
    localparam int unsigned OCT_W    = 2;
    localparam int unsigned HP_W     = 11;
    localparam int unsigned NUM_KEYS = 7;
    localparam int unsigned KEY_W    = OCT_W + NUM_KEYS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [OCT_W-1:0]  oct_t;
    typedef logic [HP_W-1:0]   hp_t;

    // Raw keyboard vector: octave on top, one-hot note keys C..B below
    typedef struct packed {
        oct_t                octave;
        logic [NUM_KEYS-1:0] keys;
    } key_vec_t;

    // LED display word; code 1..7 = C..B, 0 = nothing played yet
    typedef struct packed {
        oct_t  octave;
        note_t code;
    } led_t;

    localparam note_t NOTE_NONE = '0;

    // Octave-0 half-periods in ticks, indexed by key position (0 = C)
    function automatic hp_t base_half(input note_t idx);
        case (idx)
            3'd0:    return 11'd1911;
            3'd1:    return 11'd1703;
            3'd2:    return 11'd1517;
            3'd3:    return 11'd1432;
            3'd4:    return 11'd1276;
            3'd5:    return 11'd1136;
            3'd6:    return 11'd1012;
            default: return 11'd1911;
        endcase
    endfunction

    // Smallest result is 1012 >> 3 = 126, so never zero
    function automatic hp_t half_period(input note_t idx, input oct_t oct);
        return base_half(idx) >> oct;
    endfunction

    // Fixed priority: lowest set key index wins
    function automatic note_t lowest_key(input logic [NUM_KEYS-1:0] keys);
        note_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) idx = NOTE_W'(i);
        end
        return idx;
    endfunction

    function automatic note_t note_code(input note_t idx);
        return idx + NOTE_W'(1);
    endfunction

endpackage

// File: rtl/key_tone_scheduler_if.sv
// Keyboard-side and PWM-side signals of the tone scheduler.
//   key_input : octave + one-hot note keys (raw, asynchronous)
//   tick      : 1 MHz strobe for the PWM stage
//   tone_en   : high while a note sounds
//   tone_out  : square wave at the selected note frequency
//   led       : {octave, note_code} of the last played note
interface key_tone_scheduler_if;
    import tone_pkg::*;

    key_vec_t key_input;
    logic     tick;
    logic     tone_en;
    logic     tone_out;
    led_t     led;

    modport master (output key_input, input tick, tone_en, tone_out, led);
    modport slave  (input key_input, output tick, tone_en, tone_out, led);
endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick strobe.
//   clk, rst : system clock, async active-high reset
//   tick     : high for one clk every CLK_DIV clks (CLK_DIV >= 2)
module tick_prescaler #(
    parameter int unsigned CLK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

    logic [CNT_W-1:0] cnt;

    // tick is registered one count early so it is high exactly while cnt is last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            tick <= (cnt == CNT_PRE);
        end
    end
endmodule

// File: rtl/key_tone_scheduler.sv
// Keyboard front end: synchronise, debounce, arbitrate and sequence one note
// into a square-wave tone with a silent gap after each release.
//   clk, rst : system clock, async active-high reset
//   bus      : key_input in; tick, tone_en, tone_out, led out
module key_tone_scheduler
    import tone_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 100,
    parameter int unsigned DEBOUNCE_TICKS = 1000,
    parameter int unsigned GAP_TICKS      = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    key_tone_scheduler_if.slave  bus
);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    logic             tick;
    key_vec_t         sync1, sync2, cand, stable_keys;
    logic [DB_W-1:0]  stab_cnt, stab_inc;
    state_t           state, state_next;
    note_t            note_idx, win_idx;
    oct_t             cur_oct, pend_oct;
    hp_t              hp_cnt, half;
    logic [GAP_W-1:0] gap_cnt;
    logic             tone_en, tone_out;
    led_t             led;

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser for the raw key vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.key_input;
            sync2 <= sync1;
        end
    end

    // Stability counter saturates at DEBOUNCE_TICKS-1
    always_comb stab_inc = (stab_cnt == DB_LAST) ? stab_cnt : stab_cnt + 1'b1;

    // Debounce: accept a sample once it has been seen on DEBOUNCE_TICKS ticks in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand        <= '0;
            stab_cnt    <= '0;
            stable_keys <= '0;
        end else if (tick) begin
            if (sync2 != cand) begin
                cand     <= sync2;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_inc;
                if (stab_inc == DB_LAST) stable_keys <= cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: arbitrate in IDLE, hold until own key releases, then timed gap
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|stable_keys.keys) state_next = PLAY;
            PLAY:    if (!stable_keys.keys[note_idx]) state_next = GAP;
            GAP:     if (tick && (gap_cnt == GAP_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb win_idx = lowest_key(stable_keys.keys);
    always_comb half    = half_period(note_idx, cur_oct);

    // Tone datapath; octave changes wait in pend_oct until a toggle boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_en  <= 1'b0;
            tone_out <= 1'b0;
            led      <= '0;
            note_idx <= '0;
            cur_oct  <= '0;
            pend_oct <= '0;
            hp_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            tone_en <= (state_next == PLAY);
            case (state)
                IDLE: begin
                    if (state_next == PLAY) begin
                        note_idx <= win_idx;
                        cur_oct  <= stable_keys.octave;
                        pend_oct <= stable_keys.octave;
                        hp_cnt   <= '0;
                        tone_out <= 1'b0;
                        led      <= {stable_keys.octave, note_code(win_idx)};
                    end
                end
                PLAY: begin
                    if (state_next == GAP) begin
                        gap_cnt  <= '0;
                        tone_out <= 1'b0;
                    end else begin
                        pend_oct <= stable_keys.octave;
                        if (tick) begin
                            if (hp_cnt == half - 1'b1) begin
                                tone_out   <= ~tone_out;
                                hp_cnt     <= '0;
                                cur_oct    <= pend_oct;
                                led.octave <= pend_oct;
                            end else begin
                                hp_cnt <= hp_cnt + 1'b1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (tick) gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.tick     = tick;
    assign bus.tone_en  = tone_en;
    assign bus.tone_out = tone_out;
    assign bus.led      = led;
endmodule

// File: tb/tb_key_tone_scheduler.sv
// Self-checking bench for key_tone_scheduler: a tick-level behavioural model
// (sample history window, plain tick counting) is compared every clock, plus
// directed checks on latencies, half-periods and arbitration.
module tb_key_tone_scheduler;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DB      = 4;
    localparam int unsigned GAP     = 8;
    localparam int unsigned M_IDLE  = 0;
    localparam int unsigned M_PLAY  = 1;
    localparam int unsigned M_GAP   = 2;

    int unsigned base_hp [7] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012};

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_tone_scheduler_if kif ();

    key_tone_scheduler #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_TICKS (DB),
        .GAP_TICKS      (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int unsigned m_e;
    bit          m_tick;
    bit [8:0]    m_s1, m_s2, m_stable;
    bit [8:0]    m_hist[$];
    int unsigned m_mode, m_note, m_oct, m_pend, m_hcnt, m_gcnt;
    bit          m_tone;
    bit [4:0]    m_led;

    function automatic int unsigned lowest_key(input bit [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_e = 0; m_tick = 0; m_s1 = '0; m_s2 = '0; m_stable = '0;
        m_hist.delete();
        m_hist.push_back(9'h000);
        m_mode = M_IDLE; m_note = 0; m_oct = 0; m_pend = 0;
        m_hcnt = 0; m_gcnt = 0; m_tone = 0; m_led = '0;
    endtask

    task automatic model_step();
        bit          tick_o;
        bit [8:0]    s2_o, st_o;
        bit          same;
        tick_o = m_tick;
        s2_o   = m_s2;
        st_o   = m_stable;
        m_s2   = m_s1;
        m_s1   = kif.key_input;
        if (tick_o) begin
            m_hist.push_back(s2_o);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            if (m_hist.size() == DB) begin
                same = 1;
                foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 0;
                if (same) m_stable = m_hist[0];
            end
        end
        case (m_mode)
            M_IDLE: if (st_o[6:0] != 0) begin
                m_note = lowest_key(st_o[6:0]);
                m_oct  = st_o[8:7];
                m_pend = st_o[8:7];
                m_hcnt = 0;
                m_tone = 0;
                m_led  = {st_o[8:7], 3'(m_note + 1)};
                m_mode = M_PLAY;
            end
            M_PLAY: if (!st_o[m_note]) begin
                m_mode = M_GAP;
                m_gcnt = 0;
                m_tone = 0;
            end else begin
                if (tick_o) begin
                    m_hcnt++;
                    if (m_hcnt == (base_hp[m_note] >> m_oct)) begin
                        m_tone     = !m_tone;
                        m_hcnt     = 0;
                        m_oct      = m_pend;
                        m_led[4:3] = 2'(m_pend);
                    end
                end
                m_pend = st_o[8:7];
            end
            default: if (tick_o) begin
                m_gcnt++;
                if (m_gcnt == GAP) m_mode = M_IDLE;
            end
        endcase
        m_e++;
        m_tick = ((m_e % CLK_DIV) == CLK_DIV - 1);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- per-cycle compare and event recorder ----------------
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          en_chk    = 0;
    bit          en_seen   = 0;
    bit          prev_en   = 0;
    bit          prev_tone = 0;
    int unsigned ev[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (en_chk) begin
                check_eq("tick",     kif.tick,     m_tick);
                check_eq("tone_en",  kif.tone_en,  (m_mode == M_PLAY));
                check_eq("tone_out", kif.tone_out, m_tone);
                check_eq("led",      kif.led,      m_led);
            end
            if (kif.tone_en && (!prev_en || (kif.tone_out != prev_tone))) ev.push_back(cyc);
            if (kif.tone_en) en_seen = 1;
            prev_en   = kif.tone_en;
            prev_tone = kif.tone_out;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int unsigned n);
        repeat (n * CLK_DIV) step();
    endtask

    task automatic wait_en(input bit lvl, input int unsigned budget_ticks, input string tag);
        int unsigned k = 0;
        while ((kif.tone_en !== lvl) && (k < budget_ticks * CLK_DIV)) begin
            step();
            k++;
        end
        if (kif.tone_en !== lvl) check_eq({tag, "_timeout"}, kif.tone_en, lvl);
    endtask

    task automatic wait_events(input int n, input int unsigned budget_ticks, input string tag);
        int unsigned k = 0;
        while ((ev.size() < n) && (k < budget_ticks * CLK_DIV)) begin
            step();
            k++;
        end
        if (ev.size() < n) check_eq({tag, "_timeout"}, ev.size(), n);
    endtask

    task automatic check_tick_period(input string tag);
        int unsigned k = 0;
        while (!kif.tick && (k < 2 * CLK_DIV)) begin
            step();
            k++;
        end
        step();
        k = 1;
        while (!kif.tick && (k < 2 * CLK_DIV)) begin
            step();
            k++;
        end
        check_eq(tag, k, CLK_DIV);
    endtask

    task automatic release_all();
        kif.key_input = '0;
        wait_en(0, DB + 4, "release");
        wait_ticks(GAP + 2);
    endtask

    // First interval is measured from PLAY entry, which lands one clk after a
    // tick edge, so it is checked at tick granularity (rounded up).
    function automatic int unsigned ceil_ticks(input int unsigned clks);
        return (clks + CLK_DIV - 1) / CLK_DIV;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int unsigned k;
        kif.key_input = '0;
        repeat (3) step();
        check_eq("rst_tick",     kif.tick,     0);
        check_eq("rst_tone_en",  kif.tone_en,  0);
        check_eq("rst_tone_out", kif.tone_out, 0);
        check_eq("rst_led",      kif.led,      0);
        @(negedge clk);
        rst    = 1'b0;
        en_chk = 1;
        check_tick_period("tick_period");

        // basic note: C, octave 0
        ev.delete();
        kif.key_input = 9'b00_0000001;
        wait_en(1, DB + 4, "basic_on");
        check_eq("basic_led", kif.led, 5'b00001);
        wait_events(3, 2 * 1911 + 8, "basic_tog");
        if (ev.size() >= 3) begin
            check_eq("basic_first_half", ceil_ticks(ev[1] - ev[0]), 1911);
            check_eq("basic_half_clks",  ev[2] - ev[1], 1911 * CLK_DIV);
        end
        release_all();

        // octave shift: B, octave 3
        ev.delete();
        kif.key_input = 9'b11_1000000;
        wait_en(1, DB + 4, "oct3_on");
        check_eq("oct3_led", kif.led, 5'b11111);
        wait_events(3, 2 * 126 + 8, "oct3_tog");
        if (ev.size() >= 3) begin
            check_eq("oct3_first_half", ceil_ticks(ev[1] - ev[0]), 126);
            check_eq("oct3_half_clks",  ev[2] - ev[1], 126 * CLK_DIV);
        end
        release_all();

        // asynchronous reset in the middle of a note
        kif.key_input = 9'b00_0000100;
        wait_en(1, DB + 4, "midrst_on");
        wait_ticks(10);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_tick",     kif.tick,     0);
        check_eq("midrst_tone_en",  kif.tone_en,  0);
        check_eq("midrst_tone_out", kif.tone_out, 0);
        check_eq("midrst_led",      kif.led,      0);
        kif.key_input = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        check_tick_period("midrst_tick_period");

        // bounce: 2-tick pulses with 3-tick lows never get through
        en_seen = 0;
        repeat (6) begin
            kif.key_input = 9'b00_0000100;
            wait_ticks(2);
            kif.key_input = '0;
            wait_ticks(3);
        end
        check_eq("bounce_quiet", en_seen, 0);
        kif.key_input = 9'b00_0000100;
        wait_ticks(10);
        check_eq("bounce_hold_en",  kif.tone_en, 1);
        check_eq("bounce_hold_led", kif.led, 5'b00011);
        release_all();

        // arbitration: latched G holds against a later C
        kif.key_input = 9'b00_0010000;
        wait_en(1, DB + 4, "arb_on");
        check_eq("arb_led_g", kif.led, 5'b00101);
        kif.key_input = 9'b00_0010001;
        wait_ticks(12);
        check_eq("arb_hold_en",  kif.tone_en, 1);
        check_eq("arb_hold_led", kif.led, 5'b00101);
        kif.key_input = 9'b00_0000001;
        wait_en(0, DB + 4, "arb_rel");
        k = 0;
        while (!kif.tone_en && (k < (GAP + 4) * CLK_DIV)) begin
            step();
            k++;
        end
        // release lands one clk after a tick and re-arbitration costs one clk: they cancel
        check_eq("arb_gap_clks", k, GAP * CLK_DIV);
        check_eq("arb_led_c", kif.led, 5'b00001);
        release_all();

        // boundaries: octave alone stays idle, all keys pick C
        kif.key_input = 9'b11_0000000;
        wait_ticks(12);
        check_eq("oct_only_idle", kif.tone_en, 0);
        kif.key_input = 9'b10_1111111;
        wait_en(1, DB + 4, "all_on");
        check_eq("all_keys_led", kif.led, 5'b10001);
        release_all();

        // octave change 01 -> 10 during A
        ev.delete();
        kif.key_input = 9'b01_0100000;
        wait_en(1, DB + 4, "octchg_on");
        wait_events(2, 568 + 8, "octchg_t1");
        wait_ticks(200);
        kif.key_input = 9'b10_0100000;
        wait_events(5, 3 * 568 + 8, "octchg_t4");
        if (ev.size() >= 5) begin
            check_eq("octchg_first",  ceil_ticks(ev[1] - ev[0]), 568);
            check_eq("octchg_finish", ev[2] - ev[1], 568 * CLK_DIV);
            check_eq("octchg_new1",   ev[3] - ev[2], 284 * CLK_DIV);
            check_eq("octchg_new2",   ev[4] - ev[3], 284 * CLK_DIV);
        end
        check_eq("octchg_led", kif.led, 5'b10110);
        release_all();

        // random key traffic against the model
        repeat (60) begin
            bit [8:0] v;
            v = 9'($urandom);
            if ($urandom_range(0, 3) == 0) v[6:0] = '0;
            else if ($urandom_range(0, 1) == 0) v[6:0] = 7'(1 << $urandom_range(0, 6));
            kif.key_input = v;
            wait_ticks($urandom_range(1, 40));
        end
        release_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
